dram_queued: RTL and testbench

- Parametrised successor to the single-outstanding DRAM model that sits behind the memory bus.
- Queues requests in a small FIFO and serves them in order with configurable read/write latency.
- Adds per-byte write enables, error responses for bad address/type, and back-pressure on the response side.
- Used as the main-memory model for CPU simulation and as the template for a real controller front-end.

---
 rtl/dram_pkg.sv | 33 +++
 rtl/dram_if.sv | 30 +++
 rtl/dram_req_fifo.sv | 59 +++++
 rtl/dram_queued.sv | 200 ++++++++++++++++++++
 tb/tb_dram_queued.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dram_pkg.sv
// Shared types for the queued DRAM model: packet/engine enums and the default-width request record.
package dram_pkg;

    localparam int DRAM_ADDR_W     = 32;
    localparam int DRAM_DATA_BYTES = 8;
    localparam int DRAM_SRC_W      = 4;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        READ  = 2'd1
    } dram_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        WR_WAIT,
        RD_WAIT,
        RESP
    } dram_state_t;

    // Type is kept raw so that illegal encodings survive the queue and can be answered with an error.
    typedef struct packed {
        logic [1:0]                     pkt_type;
        logic [DRAM_ADDR_W-1:0]         addr;
        logic [8*DRAM_DATA_BYTES-1:0]   payload;
        logic [DRAM_DATA_BYTES-1:0]     byte_en;
        logic [DRAM_SRC_W-1:0]          source;
    } dram_req_t;

    function automatic logic pkt_legal(input logic [1:0] t);
        return (t == WRITE) || (t == READ);
    endfunction

endpackage

// File: rtl/dram_if.sv
// Request/response bus between a requester (master) and the DRAM model (slave).
interface dram_if #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 8,
    parameter int SRC_W      = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_type;
    logic [ADDR_W-1:0]       req_addr;
    logic [8*DATA_BYTES-1:0] req_payload;
    logic [DATA_BYTES-1:0]   req_byte_en;
    logic [SRC_W-1:0]        req_source;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [8*DATA_BYTES-1:0] resp_payload;
    logic [SRC_W-1:0]        resp_dest;
    logic                    resp_error;
    logic                    busy;

    modport master (
        output req_valid, req_type, req_addr, req_payload, req_byte_en, req_source, resp_ready,
        input  req_ready, resp_valid, resp_payload, resp_dest, resp_error, busy
    );

    modport slave (
        input  req_valid, req_type, req_addr, req_payload, req_byte_en, req_source, resp_ready,
        output req_ready, resp_valid, resp_payload, resp_dest, resp_error, busy
    );
endinterface

// File: rtl/dram_req_fifo.sv
// Request FIFO with registered full/empty flags; head entry is visible on dout while non-empty.
module dram_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]   count_reg, count_next;
    logic             full_reg, empty_reg;
    logic             do_push, do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + (PTR_W+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count_reg - (PTR_W+1)'(1);
        end
    end

    // Flags come from the next occupancy so they are plain registers, never decoded combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            full_reg  <= (count_next == (PTR_W+1)'(DEPTH));
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign full  = full_reg;
    assign empty = empty_reg;
endmodule

// File: rtl/dram_queued.sv
// Queued DRAM model: in-order request engine with byte enables, error responses and response back-pressure.
// Optional byte-wide backdoor write port is enabled by defining DRAM_BACKDOOR_EN.
module dram_queued
    import dram_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 8,
    parameter int MEM_BYTES  = 65536,
    parameter int SRC_W      = 4,
    parameter int QDEPTH     = 4,
    parameter int READ_LAT   = 4,
    parameter int WRITE_LAT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DRAM_BACKDOOR_EN
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_data,
`endif
    dram_if.slave             bus
);
    localparam int DATA_W  = 8 * DATA_BYTES;
    localparam int MIDX_W  = $clog2(MEM_BYTES);
    localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    typedef struct packed {
        logic [1:0]            pkt_type;
        logic [ADDR_W-1:0]     addr;
        logic [DATA_W-1:0]     payload;
        logic [DATA_BYTES-1:0] byte_en;
        logic [SRC_W-1:0]      source;
    } req_t;
    localparam int REQ_W = $bits(req_t);

    logic [7:0] mem [MEM_BYTES];

    req_t                  fifo_din, head;
    logic [REQ_W-1:0]      head_bits;
    logic                  fifo_full, fifo_empty, push, pop;
    logic [ADDR_W:0]       head_end;
    logic                  head_legal;

    dram_state_t           state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [MIDX_W-1:0]     cur_idx_reg, cur_idx_next;
    logic [DATA_W-1:0]     cur_payload_reg, cur_payload_next;
    logic [DATA_BYTES-1:0] cur_byte_en_reg, cur_byte_en_next;
    logic [SRC_W-1:0]      cur_source_reg, cur_source_next;
    logic [DATA_W-1:0]     resp_payload_reg, resp_payload_next;
    logic [SRC_W-1:0]      resp_dest_reg, resp_dest_next;
    logic                  resp_error_reg, resp_error_next;

    logic [MIDX_W-1:0]     rd_base;
    logic [MIDX_W-1:0]     rd_idx [DATA_BYTES];
    logic [MIDX_W-1:0]     wr_idx [DATA_BYTES];
    logic [DATA_W-1:0]     rd_data;
    logic                  commit;

    assign fifo_din = '{pkt_type: bus.req_type, addr: bus.req_addr, payload: bus.req_payload,
                        byte_en: bus.req_byte_en, source: bus.req_source};
    assign push     = bus.req_valid && !fifo_full;

    dram_req_fifo #(.DEPTH(QDEPTH), .WIDTH(REQ_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head = req_t'(head_bits);

    // One extra bit on the end address so a request near the top of the address space cannot wrap to legal.
    assign head_end   = {1'b0, head.addr} + (ADDR_W+1)'(DATA_BYTES);
    assign head_legal = pkt_legal(head.pkt_type) && (head_end <= (ADDR_W+1)'(MEM_BYTES));

    // Reads look at the head while idle (single-cycle latency) and at the held request otherwise.
    assign rd_base = (state_reg == IDLE) ? head.addr[MIDX_W-1:0] : cur_idx_reg;

    generate
        for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_bytes
            assign rd_idx[gi]            = rd_base + MIDX_W'(gi);
            assign wr_idx[gi]            = cur_idx_reg + MIDX_W'(gi);
            assign rd_data[8*gi +: 8]    = mem[rd_idx[gi]];
        end
    endgenerate

    assign commit = (state_reg == WR_WAIT) && (cnt_reg == '0);

    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        cur_idx_next      = cur_idx_reg;
        cur_payload_next  = cur_payload_reg;
        cur_byte_en_next  = cur_byte_en_reg;
        cur_source_next   = cur_source_reg;
        resp_payload_next = resp_payload_reg;
        resp_dest_next    = resp_dest_reg;
        resp_error_next   = resp_error_reg;
        pop               = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop              = 1'b1;
                    cur_idx_next     = head.addr[MIDX_W-1:0];
                    cur_payload_next = head.payload;
                    cur_byte_en_next = head.byte_en;
                    cur_source_next  = head.source;
                    if (!head_legal) begin
                        state_next        = RESP;
                        resp_payload_next = '0;
                        resp_dest_next    = head.source;
                        resp_error_next   = 1'b1;
                    end else if (head.pkt_type == WRITE) begin
                        state_next = WR_WAIT;
                        cnt_next   = CNT_W'(WRITE_LAT - 1);
                    end else if (READ_LAT == 1) begin
                        state_next        = RESP;
                        resp_payload_next = rd_data;
                        resp_dest_next    = head.source;
                        resp_error_next   = 1'b0;
                    end else begin
                        state_next = RD_WAIT;
                        cnt_next   = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            WR_WAIT: begin
                if (cnt_reg == '0) state_next = IDLE;
                else               cnt_next   = cnt_reg - CNT_W'(1);
            end
            RD_WAIT: begin
                // Capture one count early: the response register adds the final cycle of latency.
                if (cnt_reg == CNT_W'(1)) begin
                    state_next        = RESP;
                    resp_payload_next = rd_data;
                    resp_dest_next    = cur_source_reg;
                    resp_error_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            cur_idx_reg      <= '0;
            cur_payload_reg  <= '0;
            cur_byte_en_reg  <= '0;
            cur_source_reg   <= '0;
            resp_payload_reg <= '0;
            resp_dest_reg    <= '0;
            resp_error_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            cur_idx_reg      <= cur_idx_next;
            cur_payload_reg  <= cur_payload_next;
            cur_byte_en_reg  <= cur_byte_en_next;
            cur_source_reg   <= cur_source_next;
            resp_payload_reg <= resp_payload_next;
            resp_dest_reg    <= resp_dest_next;
            resp_error_reg   <= resp_error_next;
        end
    end

    // Storage is not reset; a reset clears state_reg, which blocks any pending commit.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (cur_byte_en_reg[i]) mem[wr_idx[i]] <= cur_payload_reg[8*i +: 8];
            end
        end
`ifdef DRAM_BACKDOOR_EN
        // Placed last so it overrides an engine write to the same byte.
        if (bd_we && ({1'b0, bd_addr} < (ADDR_W+1)'(MEM_BYTES))) begin
            mem[bd_addr[MIDX_W-1:0]] <= bd_data;
        end
`endif
    end

    assign bus.req_ready    = !fifo_full;
    assign bus.resp_valid   = (state_reg == RESP);
    assign bus.resp_payload = resp_payload_reg;
    assign bus.resp_dest    = resp_dest_reg;
    assign bus.resp_error   = resp_error_reg;
    assign bus.busy         = !fifo_empty || (state_reg != IDLE);
endmodule

// File: tb/tb_dram_queued.sv
// Directed bench for dram_queued: latency, byte enables, errors, back-pressure, reset abort, backdoor.
`timescale 1ns/1ps
module tb_dram_queued;
    import dram_pkg::*;

    localparam int ADDR_W     = 32;
    localparam int DATA_BYTES = 8;
    localparam int MEM_BYTES  = 65536;
    localparam int SRC_W      = 4;
    localparam int QDEPTH     = 4;
    localparam int READ_LAT   = 4;
    localparam int WRITE_LAT  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    dram_if #(.ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .SRC_W(SRC_W)) bus ();

`ifdef DRAM_BACKDOOR_EN
    logic              bd_we   = 1'b0;
    logic [ADDR_W-1:0] bd_addr = '0;
    logic [7:0]        bd_data = '0;
`endif

    dram_queued #(
        .ADDR_W(ADDR_W), .DATA_BYTES(DATA_BYTES), .MEM_BYTES(MEM_BYTES), .SRC_W(SRC_W),
        .QDEPTH(QDEPTH), .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DRAM_BACKDOOR_EN
        .bd_we   (bd_we),
        .bd_addr (bd_addr),
        .bd_data (bd_data),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [1:0] t, input logic [31:0] a, input logic [63:0] d,
                           input logic [7:0] be, input logic [3:0] s);
        int n;
        bus.req_type    = t;
        bus.req_addr    = a;
        bus.req_payload = d;
        bus.req_byte_en = be;
        bus.req_source  = s;
        bus.req_valid   = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        check("push_ready", {63'd0, bus.req_ready}, 64'd1);
        tick();
        bus.req_valid = 1'b0;
        $display("push type=%0d addr=%h data=%h be=%h src=%0d", t, a, d, be, s);
    endtask

    task automatic wait_resp(input string tag, input logic [63:0] p, input logic [3:0] dst, input logic err);
        int n;
        n = 0;
        while (!bus.resp_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, bus.resp_valid}, 64'd1);
        check({tag, "_payload"}, bus.resp_payload, p);
        check({tag, "_dest"}, {60'd0, bus.resp_dest}, {60'd0, dst});
        check({tag, "_error"}, {63'd0, bus.resp_error}, {63'd0, err});
        $display("resp %s payload=%h dest=%0d err=%0d", tag, bus.resp_payload, bus.resp_dest, bus.resp_error);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check("idle", {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int   accepted;
        logic acc;
        bus.req_valid   = 1'b0;
        bus.req_type    = 2'd0;
        bus.req_addr    = '0;
        bus.req_payload = '0;
        bus.req_byte_en = '0;
        bus.req_source  = '0;
        bus.resp_ready  = 1'b0;

        // Reset state
        repeat (3) tick();
        check("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rst_resp_payload", bus.resp_payload, 64'd0);
        check("rst_resp_dest", {60'd0, bus.resp_dest}, 64'd0);
        check("rst_resp_error", {63'd0, bus.resp_error}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Full write then read with exact latency: pop one edge after push, valid READ_LAT edges after pop
        do_push(WRITE, 32'h40, 64'h1122334455667788, 8'hFF, 4'd3);
        wait_idle();
        do_push(READ, 32'h40, 64'd0, 8'h00, 4'd5);
        check("busy_read", {63'd0, bus.busy}, 64'd1);
        for (int k = 1; k < READ_LAT; k++) begin
            tick();
            check("lat_early", {63'd0, bus.resp_valid}, 64'd0);
        end
        tick();
        check("lat_exact", {63'd0, bus.resp_valid}, 64'd1);
        wait_resp("rd_full", 64'h1122334455667788, 4'd5, 1'b0);

        // Partial write over zeros
        do_push(WRITE, 32'h80, 64'd0, 8'hFF, 4'd1);
        do_push(WRITE, 32'h80, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 4'd1);
        do_push(READ, 32'h80, 64'd0, 8'h00, 4'd2);
        wait_resp("rd_partial", 64'h00000000AAAAAAAA, 4'd2, 1'b0);

        // Highest legal beat, then out-of-range read, illegal type, wrapping address
        do_push(WRITE, 32'hFFF8, 64'h0102030405060708, 8'hFF, 4'd6);
        do_push(READ, 32'hFFF8, 64'd0, 8'h00, 4'd7);
        wait_resp("rd_top", 64'h0102030405060708, 4'd7, 1'b0);
        do_push(READ, 32'hFFF9, 64'd0, 8'h00, 4'd8);
        do_push(2'd3, 32'h80, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 4'd9);
        wait_resp("err_oob", 64'd0, 4'd8, 1'b1);
        wait_resp("err_type", 64'd0, 4'd9, 1'b1);
        do_push(READ, 32'hFFFFFFFC, 64'd0, 8'h00, 4'd11);
        wait_resp("err_wrap", 64'd0, 4'd11, 1'b1);
        do_push(READ, 32'h80, 64'd0, 8'h00, 4'd10);
        wait_resp("rd_after_err", 64'h00000000AAAAAAAA, 4'd10, 1'b0);

        // Back-pressure: one in flight plus QDEPTH queued, the sixth is refused
        bus.resp_ready  = 1'b0;
        bus.req_type    = READ;
        bus.req_addr    = 32'h40;
        bus.req_byte_en = 8'h00;
        bus.req_source  = 4'd1;
        bus.req_valid   = 1'b1;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            acc = bus.req_ready;
            tick();
            if (acc) begin
                accepted++;
                bus.req_source = 4'(accepted + 1);
            end
        end
        bus.req_valid = 1'b0;
        $display("backpressure accepted=%0d", accepted);
        check("bp_accepted", 64'(accepted), 64'(QDEPTH + 1));
        check("bp_req_ready", {63'd0, bus.req_ready}, 64'd0);
        check("bp_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
        repeat (3) tick();
        check("bp_hold_dest", {60'd0, bus.resp_dest}, 64'd1);
        check("bp_hold_payload", bus.resp_payload, 64'h1122334455667788);
        for (int s = 1; s <= 5; s++) begin
            wait_resp("drain", 64'h1122334455667788, 4'(s), 1'b0);
        end
        wait_idle();

        // Reset during RD_WAIT
        do_push(READ, 32'h40, 64'd0, 8'h00, 4'd12);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rstrd_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        check("rstrd_busy", {63'd0, bus.busy}, 64'd0);
        check("rstrd_req_ready", {63'd0, bus.req_ready}, 64'd1);
        check("rstrd_resp_dest", {60'd0, bus.resp_dest}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during WR_WAIT: write must not land
        do_push(WRITE, 32'h40, 64'hDEADBEEFCAFEF00D, 8'hFF, 4'd13);
        tick();
        rst_n = 1'b0;
        #1;
        check("rstwr_busy", {63'd0, bus.busy}, 64'd0);
        check("rstwr_resp_payload", bus.resp_payload, 64'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        do_push(READ, 32'h40, 64'd0, 8'h00, 4'd14);
        wait_resp("rd_after_rst", 64'h1122334455667788, 4'd14, 1'b0);

`ifdef DRAM_BACKDOOR_EN
        do_push(WRITE, 32'h0, 64'd0, 8'hFF, 4'd2);
        wait_idle();
        bd_we   = 1'b1;
        bd_addr = 32'd3;
        bd_data = 8'h5A;
        tick();
        bd_addr = 32'(MEM_BYTES);
        bd_data = 8'hFF;
        tick();
        bd_we = 1'b0;
        $display("backdoor writes done");
        do_push(READ, 32'h0, 64'd0, 8'h00, 4'd15);
        wait_resp("rd_backdoor", 64'h000000005A000000, 4'd15, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
